pwm_carrier_modulator: RTL
==========================

Name: pwm_carrier_modulator

Overview:
Center-aligned (triangular-carrier) PWM modulator for one inverter leg.
- Generates an up/down carrier and compares it against a double-buffered duty word.
- Produces the complementary raw gate pair that feeds the two downstream dead-time generator instances: gi_h to the high-side instance, gi_l to the low-side instance.
- Also emits carrier-synchronous event strobes for the control/ADC trigger logic.

Parameters:
WIDTH, 10, bit width of carrier, period and duty words.

Ports:
clk  input  1  main 150 MHz clock; single clock domain.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  modulator enable; low forces the safe state.
period  input  WIDTH  carrier half-period in clk cycles (triangle peak value).
duty  input  WIDTH  requested on-time per half-period, in clk cycles.
carrier  output  WIDTH  current carrier value.
dir_dn  output  1  carrier direction: 0 = counting up, 1 = counting down.
gi_h  output  1  raw high-side gate, to high-side dead-time generator.
gi_l  output  1  raw low-side gate (complement), to low-side dead-time generator.
zero_evt  output  1  one-cycle strobe at carrier valley.
peak_evt  output  1  one-cycle strobe at carrier peak.

Behaviour:
- Reset (rst_n=0, asynchronous): carrier=0, dir_dn=0, gi_h=0, gi_l=0, zero_evt=0, peak_evt=0, shadow registers (period_s, duty_s)=0.
- Shadow load:
  - When en=0, period_s and duty_s load from the inputs every cycle.
  - When en=1, they load only on the cycle where carrier==0 and dir_dn==0 (valley).
  - New values take effect from the next cycle.
- Duty clamp: duty_c = min(duty_s, period_s); computed combinationally on shadow values.
- Carrier, when en=1 and period_s>0:
  - Up phase (dir_dn=0): carrier counts 0..period_s-1. At carrier==period_s-1, the next cycle is carrier=period_s with dir_dn=1.
  - Down phase (dir_dn=1): carrier counts period_s..1. At carrier==1, the next cycle is carrier=0 with dir_dn=0.
  - Full triangle = 2*period_s cycles.
- period_s==0 with en=1: carrier holds 0, dir_dn holds 0; gate rule below still applies (duty_c=0, so gi_h=0).
- en=0:
  - Carrier forced to 0 and dir_dn to 0 synchronously.
  - gi_h=0, gi_l=0: both switches off; dead-time stages then hold both outputs low.
  - Event strobes are 0.
- Compare (combinational, from current carrier/dir_dn):
  - on = (dir_dn==0) ? (carrier < duty_c) : (carrier <= duty_c).
  - High time per triangle = exactly 2*duty_c cycles, centered on the valley.
  - duty_c==0 gives always off; duty_c==period_s gives always on.
- Gate outputs are registered, 1-cycle latency from the carrier state:
  - gi_h <= en & on.
  - gi_l <= en & ~on.
  - No glitches. gi_h and gi_l are never both 1. Dead time is NOT inserted here.
- Event strobes are registered, 1-cycle latency, aligned with the gate outputs:
  - zero_evt <= en & carrier==0 & dir_dn==0 & period_s>0.
  - peak_evt <= en & dir_dn==1 & carrier==period_s.
- en rising: the first active cycle starts at the valley with freshly loaded shadows.
- Reset mid-operation: immediate return to reset values. No state survives.
- Arithmetic: unsigned, WIDTH bits; carrier never exceeds period_s, so no wrap-around is possible.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_WIDTH (default 10), shared with the dead-time stage configuration.
  - Direction constants DIR_UP=1'b0, DIR_DN=1'b1.
- One natural sub-module: pwm_updown_counter. It contains the carrier, dir_dn and the valley/peak detection, with inputs period_s and en.
- Shadow registers, clamp, compare and output registers live in the top.

Test Plan:
1. Reset, then en=1, period=4, duty=2.
   - Carrier sequence 0,1,2,3,4,3,2,1,0…
   - gi_h high 4 of every 8 cycles (carrier 0,1 up and 2,1 down, seen one cycle later); gi_l is the exact complement.
   - zero_evt and peak_evt each pulse once per 8 cycles.
2. period=4, duty=0 and then duty=9 (clamped to 4).
   - gi_h constantly 0, then constantly 1, with gi_l complementary.
   - The change takes effect only after the next valley.
3. Mid-cycle update: period changed 4→6 and duty 2→3 while carrier=2 going up.
   - Current triangle completes with peak 4.
   - Next triangle peaks at 6 with on-time 6.
4. Drop en while gi_h=1.
   - Next cycle gi_h=0, gi_l=0, carrier=0.
   - Re-raising en restarts at the valley with current inputs.
5. Assert rst_n=0 asynchronously between clock edges during operation.
   - All outputs 0 immediately.
   - After release with en=1, period=3, duty=1: on-time is 2 cycles per 6-cycle triangle.
6. period=0, en=1.
   - Carrier stays 0; gi_h=0, gi_l=1.
   - No zero_evt or peak_evt pulses.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions.
// Holds the common word width (also used by the dead-time stage configuration)
// and the carrier direction encoding.
package pwm_pkg;

  localparam int PWM_WIDTH = 10;

  // Carrier direction encoding, as seen on dir_dn.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/pwm_updown_counter.sv
// Triangular carrier generator.
// Counts 0..period_s-1 upward, turns at period_s, and counts back down to 0.
// One full triangle therefore lasts 2*period_s cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - enable; low parks the carrier at the valley
//   period_s    - shadowed half-period (peak value)
//   carrier     - current carrier value
//   dir_dn      - 0 = counting up, 1 = counting down
//   at_valley   - combinational: carrier==0 while counting up
//   at_peak     - combinational: carrier==period_s while counting down
module pwm_updown_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] period_s,
  output logic [WIDTH-1:0] carrier,
  output logic             dir_dn,
  output logic             at_valley,
  output logic             at_peak
);

  logic [WIDTH-1:0] carrier_reg, carrier_next;
  logic             dir_reg, dir_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_reg <= '0;
      dir_reg     <= DIR_UP;
    end else begin
      carrier_reg <= carrier_next;
      dir_reg     <= dir_next;
    end
  end

  always_comb begin
    carrier_next = carrier_reg;
    dir_next     = dir_reg;
    if (!en || period_s == '0) begin
      // Disabled or zero period: park at the valley.
      carrier_next = '0;
      dir_next     = DIR_UP;
    end else if (dir_reg == DIR_UP) begin
      if (carrier_reg == period_s - WIDTH'(1)) begin
        // Land on the peak value and turn around in the same step.
        carrier_next = period_s;
        dir_next     = DIR_DN;
      end else begin
        carrier_next = carrier_reg + WIDTH'(1);
      end
    end else begin
      if (carrier_reg == WIDTH'(1)) begin
        carrier_next = '0;
        dir_next     = DIR_UP;
      end else begin
        carrier_next = carrier_reg - WIDTH'(1);
      end
    end
  end

  assign carrier   = carrier_reg;
  assign dir_dn    = dir_reg;
  assign at_valley = (dir_reg == DIR_UP) && (carrier_reg == '0);
  assign at_peak   = (dir_reg == DIR_DN) && (carrier_reg == period_s);

endmodule

// File: rtl/pwm_carrier_modulator.sv
// Center-aligned PWM modulator for one inverter leg.
// Double-buffers period/duty, clamps duty to the period, compares it against a
// triangular carrier and registers the complementary raw gate pair plus
// valley/peak strobes. Dead time is added downstream, not here.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   en                - enable; low forces both gates off
//   period, duty      - requested half-period and on-time per half-period
//   carrier, dir_dn   - carrier state
//   gi_h, gi_l        - raw high/low gates (registered, never both high)
//   zero_evt,peak_evt - one-cycle strobes aligned with the gate outputs
module pwm_carrier_modulator
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] carrier,
  output logic             dir_dn,
  output logic             gi_h,
  output logic             gi_l,
  output logic             zero_evt,
  output logic             peak_evt
);

  logic [WIDTH-1:0] period_s_reg, duty_s_reg;
  logic [WIDTH-1:0] duty_c;
  logic             at_valley, at_peak, on;
  logic             gi_h_reg, gi_l_reg, zero_evt_reg, peak_evt_reg;

  pwm_updown_counter #(.WIDTH(WIDTH)) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .period_s  (period_s_reg),
    .carrier   (carrier),
    .dir_dn    (dir_dn),
    .at_valley (at_valley),
    .at_peak   (at_peak)
  );

  // Shadows follow the inputs while idle so the first active cycle already
  // uses fresh values; while running they only update at the valley.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_s_reg <= '0;
      duty_s_reg   <= '0;
    end else if (!en || at_valley) begin
      period_s_reg <= period;
      duty_s_reg   <= duty;
    end
  end

  assign duty_c = (duty_s_reg > period_s_reg) ? period_s_reg : duty_s_reg;

  // Strict compare going up, inclusive going down: gives exactly 2*duty_c
  // high cycles per triangle, symmetric about the valley.
  assign on = (dir_dn == DIR_UP) ? (carrier < duty_c) : (carrier <= duty_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gi_h_reg     <= 1'b0;
      gi_l_reg     <= 1'b0;
      zero_evt_reg <= 1'b0;
      peak_evt_reg <= 1'b0;
    end else begin
      gi_h_reg     <= en & on;
      gi_l_reg     <= en & ~on;
      zero_evt_reg <= en & at_valley & (period_s_reg != '0);
      peak_evt_reg <= en & at_peak;
    end
  end

  assign gi_h     = gi_h_reg;
  assign gi_l     = gi_l_reg;
  assign zero_evt = zero_evt_reg;
  assign peak_evt = peak_evt_reg;

endmodule
